if_fetch_queue: RTL

Parametrised instruction-fetch stage sitting between the pre-IF stage (which issues inst_sram address requests) and the decode stage. It holds up to DEPTH fetch entries in an in-order queue and matches in-order inst_sram_data_ok responses to their entries. It presents the oldest completed entry to decode and, after a flush, discards responses still in flight for flushed requests. It generalises the single-entry IF stage: multiple outstanding requests, a configurable buffer depth and flush-safe response cancellation.

---
 rtl/if_fetch_queue_pkg.sv | 33 +++
 rtl/if_fq_cancel_ctr.sv | 50 +++++
 rtl/if_fetch_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: fs_to_ds bus layout and entry record.
package if_fetch_queue_pkg;

    localparam int FS_TO_DS_BUS_WD = 103;

    localparam int BUS_PC_LSB     = 0;
    localparam int BUS_INST_LSB   = 32;
    localparam int BUS_BADV_LSB   = 64;
    localparam int BUS_EX_BIT     = 96;
    localparam int BUS_EXCODE_LSB = 97;
    localparam int BUS_REFILL_BIT = 102;

    typedef struct packed {
        logic        tlb_refill;
        logic [4:0]  excode;
        logic        ex;
        logic [31:0] badvaddr;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_bus_t;

    typedef struct packed {
        logic        req;
        logic        filled;
        logic        ex;
        logic        tlb_refill;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/if_fq_cancel_ctr.sv
// Tracks live and cancelled inst_sram requests in flight and classifies each data_ok.
module if_fq_cancel_ctr
    import if_fetch_queue_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_push_req,
    input  logic i_data_ok,
    input  logic i_flush,
    output logic o_accept,
    output logic o_req_allow
);
    localparam int CW = $clog2(MAX_OUT) + 1;

    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_cancel_cnt;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_cancel_nxt;
    logic [CW:0]   w_sum;
    logic          w_drop;
    logic          w_accept;

    always_comb begin
        w_sum        = {1'b0, r_out_cnt} + {1'b0, r_cancel_cnt};
        w_drop       = i_data_ok && (r_cancel_cnt != '0);
        w_accept     = i_data_ok && (r_cancel_cnt == '0) && (r_out_cnt != '0);
        o_accept     = w_accept && !i_flush;
        o_req_allow  = (w_sum < (CW+1)'(MAX_OUT)) && !i_flush;
        w_out_nxt    = r_out_cnt + CW'(i_push_req) - CW'(w_accept);
        w_cancel_nxt = r_cancel_cnt - CW'(w_drop);
        if (i_flush) begin
            // every request still in flight becomes cancelled, minus the one answered now
            w_out_nxt    = '0;
            w_cancel_nxt = CW'(w_sum - (CW+1)'(i_data_ok && (w_sum != '0)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_cnt    <= '0;
            r_cancel_cnt <= '0;
        end else begin
            r_out_cnt    <= w_out_nxt;
            r_cancel_cnt <= w_cancel_nxt;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// In-order fetch queue between pre-IF and decode with flush-safe response cancellation.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pfs_to_fs_valid,
    input  logic [31:0]                  pfs_to_fs_pc,
    input  logic                         pfs_to_fs_req,
    input  logic                         pfs_to_fs_ex,
    input  logic [4:0]                   pfs_to_fs_excode,
    input  logic [31:0]                  pfs_to_fs_badvaddr,
    input  logic                         pfs_to_fs_tlb_refill,
    output logic                         fs_allowin,
    output logic                         fs_req_allow,
    input  logic                         inst_sram_data_ok,
    input  logic [31:0]                  inst_sram_rdata,
    input  logic                         ds_allowin,
    output logic                         fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0]   fs_to_ds_bus,
    output logic                         fs_inst_waiting,
    output logic [$clog2(DEPTH):0]       fs_count,
    input  logic                         do_flush
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t       r_q [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_accept;
    logic            w_found;
    logic            w_fill;
    logic            w_bypass;
    logic            w_nonempty;
    logic            w_head_rdy;
    logic [PW-1:0]   w_fill_idx;
    fq_entry_t       w_new;
    fs_to_ds_bus_t   w_bus;

    if_fq_cancel_ctr #(.MAX_OUT(MAX_OUT)) u_cancel_ctr (
        .clk         (clk),
        .reset       (reset),
        .i_push_req  (w_push && pfs_to_fs_req),
        .i_data_ok   (inst_sram_data_ok),
        .i_flush     (do_flush),
        .o_accept    (w_accept),
        .o_req_allow (fs_req_allow)
    );

    // responses are in order, so the target is the oldest requested-but-unfilled entry
    always_comb begin
        w_found    = 1'b0;
        w_fill_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = r_head + PW'(i);
            if (!w_found && (CW'(i) < r_count) && r_q[idx].req && !r_q[idx].filled) begin
                w_found    = 1'b1;
                w_fill_idx = idx;
            end
        end
    end

    always_comb begin
        w_nonempty      = (r_count != '0);
        w_fill          = w_accept && w_found;
        w_bypass        = w_fill && (w_fill_idx == r_head);
        w_head_rdy      = w_nonempty && (r_q[r_head].ex || r_q[r_head].filled || w_bypass);
        fs_to_ds_valid  = w_head_rdy && !do_flush;
        fs_allowin      = (r_count < CW'(DEPTH)) && !do_flush;
        fs_inst_waiting = w_nonempty && !w_head_rdy;
        fs_count        = r_count;
        w_push          = pfs_to_fs_valid && fs_allowin;
        w_pop           = fs_to_ds_valid && ds_allowin;

        w_new            = '0;
        w_new.req        = pfs_to_fs_req;
        w_new.ex         = pfs_to_fs_ex;
        w_new.tlb_refill = pfs_to_fs_tlb_refill;
        w_new.excode     = pfs_to_fs_excode;
        w_new.badvaddr   = pfs_to_fs_badvaddr;
        w_new.pc         = pfs_to_fs_pc;

        w_bus            = '0;
        if (fs_to_ds_valid) begin
            w_bus.tlb_refill = r_q[r_head].tlb_refill;
            w_bus.excode     = r_q[r_head].excode;
            w_bus.ex         = r_q[r_head].ex;
            w_bus.badvaddr   = r_q[r_head].badvaddr;
            w_bus.inst       = w_bypass ? inst_sram_rdata : r_q[r_head].inst;
            w_bus.pc         = r_q[r_head].pc;
        end
        fs_to_ds_bus = w_bus;
    end

    always_ff @(posedge clk) begin
        if (reset || do_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_q[r_tail] <= w_new;
                r_tail      <= r_tail + 1'b1;
            end
            if (w_fill) begin
                r_q[w_fill_idx].filled <= 1'b1;
                r_q[w_fill_idx].inst   <= inst_sram_rdata;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule
